// File: rtl/immediate_encoder_pkg.sv
// Shared type codes and error codes for the immediate encoder and the immediate decode.
package immediate_encoder_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_TYPE  = 2'b11;

endpackage

// File: rtl/imm_range_check.sv
// Combinational legality check of a signed immediate against its instruction format.
module imm_range_check
    import immediate_encoder_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] imm_i,
    input  logic [2:0]      imm_type_i,
    output logic [1:0]      err_code_o
);

    // A value fits an N-bit signed slice when every bit above N-2 is a copy of the sign.
    logic fit12, fit13, fit21, fit32;

    assign fit12 = (&imm_i[XLEN-1:11]) | ~(|imm_i[XLEN-1:11]);
    assign fit13 = (&imm_i[XLEN-1:12]) | ~(|imm_i[XLEN-1:12]);
    assign fit21 = (&imm_i[XLEN-1:20]) | ~(|imm_i[XLEN-1:20]);
    assign fit32 = (&imm_i[XLEN-1:31]) | ~(|imm_i[XLEN-1:31]);

    always_comb begin
        err_code_o = ERR_NONE;
        case (imm_type_i)
            IMM_I, IMM_S: begin
                if (!fit12) err_code_o = ERR_RANGE;
            end
            IMM_B: begin
                if (imm_i[0])    err_code_o = ERR_ALIGN;
                else if (!fit13) err_code_o = ERR_RANGE;
            end
            IMM_U: begin
                if (|imm_i[11:0]) err_code_o = ERR_ALIGN;
                else if (!fit32)  err_code_o = ERR_RANGE;
            end
            IMM_J: begin
                if (imm_i[0])    err_code_o = ERR_ALIGN;
                else if (!fit21) err_code_o = ERR_RANGE;
            end
            default: err_code_o = ERR_TYPE;
        endcase
    end

endmodule

// File: rtl/immediate_encoder.sv
// Two-stage valid/ready pipeline that scatters a checked immediate into an RV64 instruction word.
module immediate_encoder
    import immediate_encoder_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [2:0]       in_imm_type,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_error,
    output logic [1:0]       out_err_code,
    output logic [CNT_W-1:0] err_count
);

    logic [1:0] chk_code;

    imm_range_check #(
        .XLEN(XLEN)
    ) u_range_check (
        .imm_i      (in_imm),
        .imm_type_i (in_imm_type),
        .err_code_o (chk_code)
    );

    // Stage 1: request with its verdict; only the low 32 immediate bits are ever placed.
    logic        s1_valid_q;
    logic [31:0] s1_imm_q;
    logic [2:0]  s1_type_q;
    logic [31:0] s1_base_q;
    logic [1:0]  s1_code_q;

    // Stage 2: the presented result.
    logic             s2_valid_q;
    logic [31:0]      s2_instr_q;
    logic             s2_error_q;
    logic [1:0]       s2_code_q;
    logic [CNT_W-1:0] cnt_q;

    logic        s2_load, s1_adv;
    logic [31:0] packed_d;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_load;
    assign in_ready = !s1_valid_q || s1_adv;

    always_comb begin
        packed_d = s1_base_q;
        case (s1_type_q)
            IMM_I: packed_d[31:20] = s1_imm_q[11:0];
            IMM_S: begin
                packed_d[31:25] = s1_imm_q[11:5];
                packed_d[11:7]  = s1_imm_q[4:0];
            end
            IMM_B: begin
                packed_d[31]    = s1_imm_q[12];
                packed_d[7]     = s1_imm_q[11];
                packed_d[30:25] = s1_imm_q[10:5];
                packed_d[11:8]  = s1_imm_q[4:1];
            end
            IMM_U: packed_d[31:12] = s1_imm_q[31:12];
            IMM_J: begin
                packed_d[31]    = s1_imm_q[20];
                packed_d[30:21] = s1_imm_q[10:1];
                packed_d[20]    = s1_imm_q[11];
                packed_d[19:12] = s1_imm_q[19:12];
            end
            default: ;
        endcase
        if (s1_code_q != ERR_NONE) packed_d = s1_base_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_imm_q   <= '0;
            s1_type_q  <= '0;
            s1_base_q  <= '0;
            s1_code_q  <= ERR_NONE;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_error_q <= 1'b0;
            s2_code_q  <= ERR_NONE;
            cnt_q      <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_imm_q  <= in_imm[31:0];
                    s1_type_q <= in_imm_type;
                    s1_base_q <= in_base;
                    s1_code_q <= chk_code;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_instr_q <= packed_d;
                    s2_error_q <= (s1_code_q != ERR_NONE);
                    s2_code_q  <= s1_code_q;
                end
            end
            if (s2_valid_q && out_ready && s2_error_q && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_instr    = s2_instr_q;
    assign out_error    = s2_error_q;
    assign out_err_code = s2_code_q;
    assign err_count    = cnt_q;

endmodule

// File: tb/tb_immediate_encoder.sv
// Scoreboard bench: accepted requests queue their expected result; a monitor pops on consume.
module tb_immediate_encoder;

    localparam int unsigned TB_CNT_W = 8;
    localparam logic [TB_CNT_W-1:0] CNT_MAX = '1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [63:0]         in_imm = '0;
    logic [2:0]          in_imm_type = '0;
    logic [31:0]         in_base = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [31:0]         out_instr;
    logic                out_error;
    logic [1:0]          out_err_code;
    logic [TB_CNT_W-1:0] err_count;

    immediate_encoder #(
        .XLEN  (64),
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_imm       (in_imm),
        .in_imm_type  (in_imm_type),
        .in_base      (in_base),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_error    (out_error),
        .out_err_code (out_err_code),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  t;
        logic [31:0] instr;
        logic [1:0]  code;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic [TB_CNT_W-1:0] exp_cnt = '0;
    logic        dir_en = 1'b0;
    logic [31:0] dir_instr = '0;
    logic [1:0]  dir_code = '0;
    logic        rand_rdy = 1'b0;
    logic        stall = 1'b0;
    logic [34:0] held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: legality from numeric bounds, placement from the field table.
    function automatic exp_t model(input logic [63:0] imm, input logic [2:0] t,
                                   input logic [31:0] base);
        exp_t   e;
        longint s;
        s = longint'(imm);
        e.imm = imm;
        e.t = t;
        e.code = 2'b00;
        case (t)
            3'd0, 3'd1: if (s < -64'sd2048 || s > 64'sd2047) e.code = 2'b01;
            3'd2: begin
                if (imm[0]) e.code = 2'b10;
                else if (s < -64'sd4096 || s > 64'sd4095) e.code = 2'b01;
            end
            3'd3: begin
                if (imm[11:0] != 12'd0) e.code = 2'b10;
                else if (s < -64'sd2147483648 || s > 64'sd2147483647) e.code = 2'b01;
            end
            3'd4: begin
                if (imm[0]) e.code = 2'b10;
                else if (s < -64'sd1048576 || s > 64'sd1048575) e.code = 2'b01;
            end
            default: e.code = 2'b11;
        endcase
        e.instr = base;
        if (e.code == 2'b00) begin
            case (t)
                3'd0: e.instr[31:20] = imm[11:0];
                3'd1: begin e.instr[31:25] = imm[11:5]; e.instr[11:7] = imm[4:0]; end
                3'd2: begin
                    e.instr[31] = imm[12]; e.instr[7] = imm[11];
                    e.instr[30:25] = imm[10:5]; e.instr[11:8] = imm[4:1];
                end
                3'd3: e.instr[31:12] = imm[31:12];
                default: begin
                    e.instr[31] = imm[20]; e.instr[30:21] = imm[10:1];
                    e.instr[20] = imm[11]; e.instr[19:12] = imm[19:12];
                end
            endcase
        end
        return e;
    endfunction

    function automatic logic [63:0] decode(input logic [31:0] w, input logic [2:0] t);
        logic [11:0] v12;
        logic [12:0] v13;
        logic [20:0] v21;
        logic [31:0] v32;
        case (t)
            3'd0: begin v12 = w[31:20]; return longint'($signed(v12)); end
            3'd1: begin v12 = {w[31:25], w[11:7]}; return longint'($signed(v12)); end
            3'd2: begin
                v13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                return longint'($signed(v13));
            end
            3'd3: begin v32 = {w[31:12], 12'd0}; return longint'($signed(v32)); end
            default: begin
                v21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                return longint'($signed(v21));
            end
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && in_valid && in_ready) begin
            e = model(in_imm, in_imm_type, in_base);
            if (dir_en) begin
                e.instr = dir_instr;
                e.code  = dir_code;
            end
            q.push_back(e);
            acc_cnt++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q.delete();
            exp_cnt = '0;
            stall = 1'b0;
        end else begin
            chk("err_count", 64'(err_count), 64'(exp_cnt));
            if (stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_word", 64'({out_instr, out_error, out_err_code}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h with nothing outstanding", out_instr);
                end else begin
                    e = q.pop_front();
                    chk("instr", 64'(out_instr), 64'(e.instr));
                    chk("err_code", 64'(out_err_code), 64'(e.code));
                    chk("error", 64'(out_error), 64'(e.code != 2'b00));
                    if (e.code == 2'b00 && out_error == 1'b0) begin
                        chk("roundtrip", decode(out_instr, e.t), e.imm);
                    end
                    if (e.code != 2'b00 && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
                end
            end
            stall = out_valid && !out_ready;
            held  = {out_instr, out_error, out_err_code};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] imm, input logic [2:0] t, input logic [31:0] base);
        int   n = 0;
        logic acc;
        in_valid = 1'b1;
        in_imm = imm;
        in_imm_type = t;
        in_base = base;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_dir(input logic [63:0] imm, input logic [2:0] t, input logic [31:0] base,
                            input logic [31:0] instr, input logic [1:0] code);
        dir_en = 1'b1;
        dir_instr = instr;
        dir_code = code;
        send(imm, t, base);
        dir_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic rand_req(output logic [63:0] imm, output logic [2:0] t,
                            output logic [31:0] base);
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0: imm = r;
            1: imm = longint'(r << 52) >>> 52;
            2: begin
                imm = longint'(r << 51) >>> 51;
                if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;
            end
            3: begin
                imm = longint'(r << 43) >>> 43;
                if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;
            end
            default: begin
                imm = longint'(r << 32) >>> 32;
                if ($urandom_range(0, 3) != 0) imm[11:0] = 12'd0;
            end
        endcase
        t = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        base = $urandom;
    endtask

    initial begin
        logic [63:0] imm;
        logic [2:0]  t;
        logic [31:0] base;
        logic [63:0] vi[5];
        logic [2:0]  vt[5];
        logic [31:0] vb[5];
        int          idx;
        int          start;

        fork
            forever begin
                tick();
                if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            end
        join_none

        repeat (3) tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_error", 64'(out_error), 64'd0);
        chk("rst_code", 64'(out_err_code), 64'd0);
        chk("rst_count", 64'(err_count), 64'd0);
        reset = 1'b0;
        tick();

        send_dir(64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 32'h0000_0013, 32'hFFF0_0013, 2'b00);
        send_dir(-64'sd4096, 3'd2, 32'h0000_0063, 32'h8000_0063, 2'b00);
        send_dir(-64'sd2, 3'd4, 32'h0000_006F, 32'hFFFF_F06F, 2'b00);
        send_dir(64'h1234_5000, 3'd3, 32'h0000_0037, 32'h1234_5037, 2'b00);
        send_dir(64'd2048, 3'd0, 32'h0000_0013, 32'h0000_0013, 2'b01);
        send_dir(64'd3, 3'd2, 32'h0000_0063, 32'h0000_0063, 2'b10);
        send_dir(64'd0, 3'b101, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11);
        drain();
        chk("dir_err_count", 64'(err_count), 64'd3);

        // Five back-to-back requests against a stalled consumer.
        for (int i = 0; i < 5; i++) rand_req(vi[i], vt[i], vb[i]);
        idx = 0;
        start = acc_cnt;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_imm = vi[idx];
            in_imm_type = vt[idx];
            in_base = vb[idx];
            @(negedge clk);
            if (in_ready) idx++;
            tick();
        end
        chk("bp_accepts", 64'(acc_cnt - start), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        while (idx < 5) begin
            send(vi[idx], vt[idx], vb[idx]);
            idx++;
        end
        drain();

        // Reset with two requests in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_req(imm, t, base);
            send(imm, t, base);
        end
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_instr", 64'(out_instr), 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_quiet", 64'(out_valid), 64'd0);
        end

        rand_rdy = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            rand_req(imm, t, base);
            send(imm, t, base);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_rdy = 1'b0;
        tick();
        drain();

        // Push the error counter into saturation and beyond.
        for (int i = 0; i < 300; i++) begin
            rand_req(imm, t, base);
            send(imm, 3'($urandom_range(5, 7)), base);
        end
        drain();
        repeat (2) tick();
        chk("sat_count", 64'(err_count), 64'(CNT_MAX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
